// File: rtl/shared_complex_mul.sv
// Time-shared complex butterfly unit: four lanes of r_p = m + n*l and r_m = m - n*l,
// one shared complex multiplier, one new input set every five fast-clock cycles.
module shared_complex_mul #(
    parameter int  p_inputWidth    = 8,
    parameter int  p_PointPosition = 6,
    localparam int W               = p_inputWidth,
    localparam int M               = 2 * p_inputWidth - p_PointPosition + 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [2*W-1:0] i_m1,
    input  logic [2*W-1:0] i_m2,
    input  logic [2*W-1:0] i_m3,
    input  logic [2*W-1:0] i_m4,
    input  logic [2*W-1:0] i_n1,
    input  logic [2*W-1:0] i_n2,
    input  logic [2*W-1:0] i_n3,
    input  logic [2*W-1:0] i_n4,
    input  logic [2*W-1:0] i_l1,
    input  logic [2*W-1:0] i_l2,
    input  logic [2*W-1:0] i_l3,
    input  logic [2*W-1:0] i_l4,
    output logic [2*M-1:0] o_r1_p,
    output logic [2*M-1:0] o_r2_p,
    output logic [2*M-1:0] o_r3_p,
    output logic [2*M-1:0] o_r4_p,
    output logic [2*M-1:0] o_r1_m,
    output logic [2*M-1:0] o_r2_m,
    output logic [2*M-1:0] o_r3_m,
    output logic [2*M-1:0] o_r4_m
);

    localparam int P  = p_PointPosition;
    localparam int PW = 2 * W + 1;
    localparam int L  = 4;

    logic [2*W-1:0] m_in [L];
    logic [2*W-1:0] n_in [L];
    logic [2*W-1:0] l_in [L];

    assign m_in[0] = i_m1;
    assign m_in[1] = i_m2;
    assign m_in[2] = i_m3;
    assign m_in[3] = i_m4;
    assign n_in[0] = i_n1;
    assign n_in[1] = i_n2;
    assign n_in[2] = i_n3;
    assign n_in[3] = i_n4;
    assign l_in[0] = i_l1;
    assign l_in[1] = i_l2;
    assign l_in[2] = i_l3;
    assign l_in[3] = i_l4;

    logic [2:0]     ph_q, ph_d;
    logic [2*W-1:0] m_q [L], m_d [L];
    logic [2*W-1:0] n_q [L], n_d [L];
    logic [2*W-1:0] l_q [L], l_d [L];
    logic [2*M-1:0] res_p_q [L], res_p_d [L];
    logic [2*M-1:0] res_m_q [L], res_m_d [L];
    logic [2*M-1:0] out_p_q [L], out_p_d [L];
    logic [2*M-1:0] out_m_q [L], out_m_d [L];

    logic [1:0]          lane;
    logic signed [W-1:0] mr, mi, nr, ni, lr, li;
    logic signed [PW-1:0] prod_re_full, prod_im_full;
    logic signed [M-1:0] prod_re, prod_im;
    logic signed [M-1:0] rp_re, rp_im, rm_re, rm_im;

    // Phase k (1..4) drives lane k-1 through the shared multiplier; the phase-0
    // value selects lane 3 but its result is never stored.
    always_comb begin : shared_datapath
        lane = 2'(ph_q - 3'd1);
        mr   = m_q[lane][2*W-1:W];
        mi   = m_q[lane][W-1:0];
        nr   = n_q[lane][2*W-1:W];
        ni   = n_q[lane][W-1:0];
        lr   = l_q[lane][2*W-1:W];
        li   = l_q[lane][W-1:0];

        prod_re_full = PW'(nr) * PW'(lr) - PW'(ni) * PW'(li);
        prod_im_full = PW'(nr) * PW'(li) + PW'(ni) * PW'(lr);

        // Floor shift leaves exactly M significant bits, so the cast never drops sign.
        prod_re = M'(prod_re_full >>> P);
        prod_im = M'(prod_im_full >>> P);

        rp_re = M'(mr) + prod_re;
        rp_im = M'(mi) + prod_im;
        rm_re = M'(mr) - prod_re;
        rm_im = M'(mi) - prod_im;
    end

    always_comb begin : next_state
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
        ph_d    = (ph_q == 3'd4) ? 3'd0 : ph_q + 3'd1;
        m_d     = m_q;
        n_d     = n_q;
        l_d     = l_q;
        res_p_d = res_p_q;
        res_m_d = res_m_q;
        out_p_d = out_p_q;
        out_m_d = out_m_q;

        if (ph_q == 3'd0) begin
            m_d     = m_in;
            n_d     = n_in;
            l_d     = l_in;
            out_p_d = res_p_q;
            out_m_d = res_m_q;
        end else begin
            res_p_d[lane] = {rp_re, rp_im};
            res_m_d[lane] = {rm_re, rm_im};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the small holding/result arrays are flops, not RAM, and are cleared
            // so a mid-frame reset cannot leak partial lane results to the outputs.
            ph_q    <= '0;
            m_q     <= '{default: '0};
            n_q     <= '{default: '0};
            l_q     <= '{default: '0};
            res_p_q <= '{default: '0};
            res_m_q <= '{default: '0};
            out_p_q <= '{default: '0};
            out_m_q <= '{default: '0};
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            ph_q    <= ph_d;
            m_q     <= m_d;
            n_q     <= n_d;
            l_q     <= l_d;
            res_p_q <= res_p_d;
            res_m_q <= res_m_d;
            out_p_q <= out_p_d;
            out_m_q <= out_m_d;
        end
    end

    assign o_r1_p = out_p_q[0];
    assign o_r2_p = out_p_q[1];
    assign o_r3_p = out_p_q[2];
    assign o_r4_p = out_p_q[3];
    assign o_r1_m = out_m_q[0];
    assign o_r2_m = out_m_q[1];
    assign o_r3_m = out_m_q[2];
    assign o_r4_m = out_m_q[3];

endmodule

// File: tb/tb_shared_complex_mul.sv
// Self-checking bench for shared_complex_mul: reset, directed butterflies, input hold,
// random frames against a reference model, and mid-frame reset recovery.
module tb_shared_complex_mul;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] i_m1, i_m2, i_m3, i_m4;
    logic [15:0] i_n1, i_n2, i_n3, i_n4;
    logic [15:0] i_l1, i_l2, i_l3, i_l4;
    logic [21:0] o_r1_p, o_r2_p, o_r3_p, o_r4_p;
    logic [21:0] o_r1_m, o_r2_m, o_r3_m, o_r4_m;

    int total = 0;
    int bad   = 0;

    logic [3:0][21:0] pend_p, pend_m, shown_p, shown_m;
    logic [3:0][15:0] d_m, d_n, d_l;
    logic [3:0][21:0] d_p, d_mr, zero_r;
    logic [3:0][15:0] zero_in;

    shared_complex_mul #(
        .p_inputWidth   (8),
        .p_PointPosition(6)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .i_m1  (i_m1),
        .i_m2  (i_m2),
        .i_m3  (i_m3),
        .i_m4  (i_m4),
        .i_n1  (i_n1),
        .i_n2  (i_n2),
        .i_n3  (i_n3),
        .i_n4  (i_n4),
        .i_l1  (i_l1),
        .i_l2  (i_l2),
        .i_l3  (i_l3),
        .i_l4  (i_l4),
        .o_r1_p(o_r1_p),
        .o_r2_p(o_r2_p),
        .o_r3_p(o_r3_p),
        .o_r4_p(o_r4_p),
        .o_r1_m(o_r1_m),
        .o_r2_m(o_r2_m),
        .o_r3_m(o_r3_m),
        .o_r4_m(o_r4_m)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [21:0] get_p(input int i);
        case (i)
            0:       return o_r1_p;
            1:       return o_r2_p;
            2:       return o_r3_p;
            default: return o_r4_p;
        endcase
    endfunction

    function automatic logic [21:0] get_m(input int i);
        case (i)
            0:       return o_r1_m;
            1:       return o_r2_m;
            2:       return o_r3_m;
            default: return o_r4_m;
        endcase
    endfunction

    task automatic set_inputs(input logic [3:0][15:0] m, input logic [3:0][15:0] n,
                              input logic [3:0][15:0] l);
        i_m1 = m[0]; i_m2 = m[1]; i_m3 = m[2]; i_m4 = m[3];
        i_n1 = n[0]; i_n2 = n[1]; i_n3 = n[2]; i_n4 = n[3];
        i_l1 = l[0]; i_l2 = l[1]; i_l3 = l[2]; i_l4 = l[3];
    endtask

    task automatic scramble_inputs();
        logic [3:0][15:0] m, n, l;
        for (int i = 0; i < 4; i++) begin
            m[i] = 16'($urandom);
            n[i] = 16'($urandom);
            l[i] = 16'($urandom);
        end
        set_inputs(m, n, l);
    endtask

    task automatic check_all(input string name, input logic [3:0][21:0] ep,
                             input logic [3:0][21:0] em);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_r%0d_p", name, i + 1), 64'(get_p(i)), 64'(ep[i]));
            check($sformatf("%s_r%0d_m", name, i + 1), 64'(get_m(i)), 64'(em[i]));
        end
    endtask

    // Reference butterfly in plain integer arithmetic (W=8, P=6, M=11).
    function automatic logic [21:0] model(input logic [15:0] m, input logic [15:0] n,
                                          input logic [15:0] l, input bit minus);
        int mr, mi, nr, ni, lr, li, pr, pi, re, im;
        mr = int'($signed(m[15:8]));
        mi = int'($signed(m[7:0]));
        nr = int'($signed(n[15:8]));
        ni = int'($signed(n[7:0]));
        lr = int'($signed(l[15:8]));
        li = int'($signed(l[7:0]));
        pr = (nr * lr - ni * li) >>> 6;
        pi = (nr * li + ni * lr) >>> 6;
        re = minus ? mr - pr : mr + pr;
        im = minus ? mi - pi : mi + pi;
        return {re[10:0], im[10:0]};
    endfunction

    // One 5-cycle frame: capture at the first edge, where the previous frame's results
    // must appear, then four edges over which those outputs must hold.
    task automatic frame(input string name, input logic [3:0][15:0] m,
                         input logic [3:0][15:0] n, input logic [3:0][15:0] l,
                         input logic [3:0][21:0] ep, input logic [3:0][21:0] em,
                         input bit scramble);
        set_inputs(m, n, l);
        tick();
        check_all({name, "_lat"}, pend_p, pend_m);
        shown_p = pend_p;
        shown_m = pend_m;
        pend_p  = ep;
        pend_m  = em;
        for (int k = 1; k <= 4; k++) begin
            if (scramble) scramble_inputs();
            tick();
            check_all({name, "_hold"}, shown_p, shown_m);
        end
    endtask

    initial begin
        logic [3:0][15:0] rm, rn, rl;
        logic [3:0][21:0] rp, rq;

        zero_in = '0;
        zero_r  = '0;
        d_m[0] = 16'h4000; d_n[0] = 16'h4000; d_l[0] = 16'h4000;
        d_m[1] = 16'h0000; d_n[1] = 16'h0040; d_l[1] = 16'h0040;
        d_m[2] = 16'h0000; d_n[2] = 16'h8080; d_l[2] = 16'h8080;
        d_m[3] = 16'h0000; d_n[3] = 16'hFF00; d_l[3] = 16'h0100;
        d_p[0] = 22'h040000; d_mr[0] = 22'h000000;
        d_p[1] = 22'h3E0000; d_mr[1] = 22'h020000;
        d_p[2] = 22'h000200; d_mr[2] = 22'h000600;
        d_p[3] = 22'h3FF800; d_mr[3] = 22'h000800;

        RST = 1'b1;
        scramble_inputs();
        for (int c = 0; c < 15; c++) begin
            tick();
            check_all("reset", zero_r, zero_r);
            scramble_inputs();
        end

        pend_p = '0;
        pend_m = '0;
        RST    = 1'b0;
        frame("dir_a", d_m, d_n, d_l, d_p, d_mr, 1'b0);
        frame("dir_b", d_m, d_n, d_l, d_p, d_mr, 1'b1);
        frame("dir_c", d_m, d_n, d_l, d_p, d_mr, 1'b1);

        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < 4; i++) begin
                rm[i] = 16'($urandom);
                rn[i] = 16'($urandom);
                rl[i] = 16'($urandom);
                rp[i] = model(rm[i], rn[i], rl[i], 1'b0);
                rq[i] = model(rm[i], rn[i], rl[i], 1'b1);
            end
            frame("rand", rm, rn, rl, rp, rq, 1'b1);
        end

        frame("pre_rst", d_m, d_n, d_l, d_p, d_mr, 1'b0);
        set_inputs(d_m, d_n, d_l);
        tick();
        check_all("mid_cap", pend_p, pend_m);
        tick();
        RST = 1'b1;
        tick();
        check_all("mid_rst", zero_r, zero_r);
        RST    = 1'b0;
        pend_p = '0;
        pend_m = '0;
        frame("post_a", d_m, d_n, d_l, d_p, d_mr, 1'b1);
        frame("post_b", zero_in, zero_in, zero_in, zero_r, zero_r, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_complex_mul.md
# shared_complex_mul

Time-shared complex multiply/butterfly unit for the 32-point FFT datapath. It computes four complex butterflies per input set, r_p = m + n·l and r_m = m − n·l, in signed fixed point. A single complex multiplier is reused across all four lanes. The unit runs on a fast clock equal to 5× the sample rate, and its outputs are captured downstream by plain load registers (`Register`) on the slow sample clock.

## Interface
- p_inputWidth, 8, bits per real/imag component (W), signed two's complement
- p_PointPosition, 6, fractional bits of the input format (P)
- Derived: M = 2·W − P + 1 (bits per output component; 11 at defaults)

- CLK  in  1  fast clock (5× sample rate); all state on rising edge
- RST  in  1  reset; one clock, synchronous, active-high
- i_m1..i_m4  in  2W  complex addend m; [2W-1:W] real, [W-1:0] imag
- i_n1..i_n4  in  2W  complex multiplicand n; same packing
- i_l1..i_l4  in  2W  complex multiplier l (twiddle); same packing
- o_r1_p..o_r4_p  out  2M  m + n·l; [2M-1:M] real, [M-1:0] imag
- o_r1_m..o_r4_m  out  2M  m − n·l; same packing

## Operation
- Phase counter ph cycles 0,1,2,3,4,0,… on every CLK edge.
- Edge with ph=0:
  - All 12 inputs are captured into holding registers.
  - The four lane results from the previous frame are copied to the o_r* outputs simultaneously.
- Edge with ph=k (k=1..4): lane k is computed from the holding registers and written to result register k. One shared complex multiplier and adder/subtractor serve all lanes.
- Product, lane k (full precision before the shift):
  - pr = (nr·lr − ni·li) >>> P
  - pi = (nr·li + ni·lr) >>> P
  - W×W signed products are 2W bits; the sum/difference is 2W+1 bits.
  - The arithmetic right shift is floor rounding and yields exactly M bits, so the product never overflows.
- Butterfly:
  - r_p = sext(m) + p
  - r_m = sext(m) − p
  - Each part is computed in M bits and wraps modulo 2^M on overflow (no saturation).
- Lanes are fully independent. Lane k's outputs depend only on i_mk, i_nk, i_lk.

## Timing
- Reset:
  - ph, holding registers, result registers and all o_r* outputs are 0 on the edge where RST=1.
  - The first ph=0 edge is the first edge with RST=0.
  - RST asserted mid-frame aborts the frame: all state returns to 0 and partial lane results are discarded.
- Phase alignment: RST must be released coincident with a slow-clock edge. The ph=0 edges then coincide with the slow-clock edges.
- Inputs are sampled only at ph=0 edges. Input changes on other edges are ignored.
- Latency:
  - Inputs sampled at ph=0 edge t appear on outputs at edge t+5 (next ph=0 edge).
  - That is one sample period; the downstream slow register sees them one slow edge later.
- Outputs are stable for the full 5 cycles between ph=0 edges and change only at ph=0 edges.
- Throughput: one full 4-lane set every 5 CLK cycles. Ph=0 performs no multiplication.
- No handshake and no valid signal; operation is free-running.

## Test plan
Defaults W=8, P=6 (1.0 = 0x40, M=11, 22-bit outputs).
- Reset: RST=1 for 15 CLK, inputs random → all o_r* = 0 throughout. After release, the first nonzero outputs appear exactly 5 CLK after the first ph=0 capture.
- Unity: m1=n1=l1=0x4000 (1+0j) → o_r1_p = 22'h040000 (real 128), o_r1_m = 0.
- j·j: m2=0, n2=l2=0x0040 → o_r2_p real = 11'h7C0 (−64), imag 0; o_r2_m real = 11'h040 (+64).
- Extremes and rounding:
  - n3=l3=0x8080 (−2−2j), m3=0 → o_r3_p real 0, imag 512 (11'h200); o_r3_m imag 11'h600.
  - n4=0xFF00, l4=0x0100, m4=0 → product real = −1 (floor), o_r4_p real = 11'h7FF.
- Hold/timing: change inputs on non-ph0 edges → outputs unchanged. Random inputs every 5 CLK for 1000 frames → each lane matches the reference model (floor, wrap) with 5-cycle latency.
- Mid-frame reset: RST pulsed at ph=2 → outputs 0 next edge; the frame restarts cleanly with ph=0 on the first edge with RST=0.
